game_sprite_motion: RTL and testbench
=====================================

Name: game_sprite_motion

Overview:
- Per-sprite position generator that sits directly upstream of the pipelined sprite display stage.
- Holds the sprite's current x/y and signed per-step velocity. Advances the position once every UPDATE_DIV frame strobes while enabled.
- Drives sprite_x/sprite_y into the display stage, which handles off-screen detection and pixel rendering.
- Game control logic loads position and velocity through one-cycle write strobes.

Parameters:
DX_WIDTH, 2, width of signed x velocity (two's complement)
DY_WIDTH, 2, width of signed y velocity (two's complement)
UPDATE_DIV, 4, frame strobes per position step; legal range 1..255

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-low (asserted when 0)
frame_strobe  input  1  one-cycle pulse per video frame (end of active area)
enable_update  input  1  level; 1 = sprite may move
write_xy  input  1  one-cycle strobe: load position
write_x  input  `X_WIDTH  position x loaded on write_xy
write_y  input  `Y_WIDTH  position y loaded on write_xy
write_dxy  input  1  one-cycle strobe: load velocity
write_dx  input  DX_WIDTH  signed x velocity loaded on write_dxy
write_dy  input  DY_WIDTH  signed y velocity loaded on write_dxy
sprite_x  output  `X_WIDTH  current sprite left coordinate (registered)
sprite_y  output  `Y_WIDTH  current sprite top coordinate (registered)
sprite_moving  output  1  1 while in state MOVING
step_pulse  output  1  one-cycle pulse in the cycle sprite_x/sprite_y take a stepped value

Behaviour:
- All state changes on posedge clk. Reset is sampled only on the clock edge.
- Reset (reset==0):
  - sprite_x=0, sprite_y=0; dx=dy=0; divider counter=0.
  - state=IDLE; sprite_moving=0, step_pulse=0.
  - Reset overrides every other input in the same cycle. Reset mid-step discards the pending step.
- FSM states: IDLE, ARMED, MOVING.
  - IDLE -> ARMED on write_xy. In IDLE, frame_strobe is ignored and the counter holds 0.
  - ARMED -> MOVING when enable_update==1.
  - MOVING -> ARMED when enable_update==0.
  - write_xy never changes ARMED or MOVING. There is no path back to IDLE except reset.
- Loads:
  - write_xy: sprite_x/sprite_y take write_x/write_y on the next edge and the divider counter clears to 0. Legal in any state.
  - write_dxy: dx/dy take write_dx/write_dy on the next edge. Legal in any state, including IDLE.
  - Simultaneous write_xy and write_dxy: both load.
- Divider:
  - Counts only when state==MOVING, frame_strobe==1, and write_xy==0 in the same cycle.
  - If counter==UPDATE_DIV-1: counter goes to 0 and a step occurs. Otherwise counter increments.
  - Counter width is ceil(log2(UPDATE_DIV)), minimum 1 bit.
  - With UPDATE_DIV==1, every qualifying strobe steps.
- Step:
  - sprite_x <= sprite_x + sign-extended dx; sprite_y <= sprite_y + sign-extended dy.
  - Arithmetic is modulo 2^`X_WIDTH and 2^`Y_WIDTH, with silent wrap-around. Off-screen detection belongs to the display stage.
  - step_pulse=1 in the cycle after the stepping edge, i.e. registered and coincident with the new position. It is 0 otherwise.
  - A step with dx==dy==0 still pulses step_pulse.
- Simultaneous events:
  - write_xy with a qualifying frame_strobe: the load wins, no step, counter=0.
  - write_dxy with a stepping strobe: the step uses the old dx/dy; the new velocity applies from the next step.
- MOVING->ARMED transition: the counter holds its value and resumes counting on re-entry to MOVING.
- frame_strobe in the same cycle as the ARMED->MOVING transition does not count. State must already be MOVING when the strobe is sampled.
- Latency: write to output is 1 cycle. The step appears on outputs 1 cycle after the qualifying strobe edge.
- Outputs are purely registered; no combinational path from inputs to outputs.

Test Plan (X_WIDTH=10, Y_WIDTH=10, UPDATE_DIV=4, DX/DY_WIDTH=2):
- Reset: hold reset=0 for 3 cycles with random inputs -> sprite_x=0, sprite_y=0, sprite_moving=0, step_pulse=0. Strobes in IDLE never move the sprite.
- Basic motion:
  - write_xy (100,50), write_dxy (+1,-1), enable_update=1, then 8 frame strobes.
  - -> sprite at (101,49) after the 4th strobe and (102,48) after the 8th.
  - step_pulse high exactly twice; sprite_moving=1 throughout.
- Wrap: write_xy (1023,0), dx=+1, dy=-1, 4 strobes -> sprite at (0,1023), step_pulse once.
- Simultaneity:
  - write_xy (10,10) on the same cycle as the 4th strobe -> sprite (10,10), no step_pulse, counter restarts. The next step occurs only after 4 more strobes.
  - write_dxy (-2,+1) coincident with a stepping strobe -> that step uses the old velocity; the following step uses (-2,+1).
- Pause:
  - Drop enable_update after 2 strobes -> sprite_moving=0, strobes ignored.
  - Re-enable -> the step fires after 2 further strobes, not 4.
- Mid-operation reset: reset=0 for one cycle while MOVING with counter=3 -> all outputs 0, state IDLE. Subsequent strobes cause no motion until write_xy.

Source files
------------

// File: rtl/game_sprite_motion_if.sv
// Bundle between game control / display stage and the sprite motion block.
// slave is the motion block's view; master is the driver (control logic or bench).
interface game_sprite_motion_if #(
   parameter int X_WIDTH  = 10,
   parameter int Y_WIDTH  = 10,
   parameter int DX_WIDTH = 2,
   parameter int DY_WIDTH = 2
);
   logic                frame_strobe;
   logic                enable_update;
   logic                write_xy;
   logic [X_WIDTH-1:0]  write_x;
   logic [Y_WIDTH-1:0]  write_y;
   logic                write_dxy;
   logic [DX_WIDTH-1:0] write_dx;
   logic [DY_WIDTH-1:0] write_dy;
   logic [X_WIDTH-1:0]  sprite_x;
   logic [Y_WIDTH-1:0]  sprite_y;
   logic                sprite_moving;
   logic                step_pulse;

   modport slave (
      input  frame_strobe, enable_update,
      input  write_xy, write_x, write_y,
      input  write_dxy, write_dx, write_dy,
      output sprite_x, sprite_y, sprite_moving, step_pulse
   );

   modport master (
      output frame_strobe, enable_update,
      output write_xy, write_x, write_y,
      output write_dxy, write_dx, write_dy,
      input  sprite_x, sprite_y, sprite_moving, step_pulse
   );
endinterface

// File: rtl/game_sprite_motion.sv
// Per-sprite position generator: steps x/y by a signed velocity once every
// UPDATE_DIV frame strobes while MOVING; position/velocity loaded by strobes.
module game_sprite_motion #(
   parameter int X_WIDTH    = 10,
   parameter int Y_WIDTH    = 10,
   parameter int DX_WIDTH   = 2,
   parameter int DY_WIDTH   = 2,
   parameter int UPDATE_DIV = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   game_sprite_motion_if.slave   bus
);

   localparam int CNT_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      MOVING = 2'd2
   } state_e;

   state_e              state_q;
   logic [X_WIDTH-1:0]  x_q;
   logic [Y_WIDTH-1:0]  y_q;
   logic [DX_WIDTH-1:0] dx_q;
   logic [DY_WIDTH-1:0] dy_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                moving_q;
   logic                step_q;

   logic [X_WIDTH-1:0]  x_d;
   logic [Y_WIDTH-1:0]  y_d;
   logic                count_en;
   logic                cnt_last;

   // A load on write_xy always beats a strobe arriving in the same cycle.
   assign count_en = (state_q == MOVING) && bus.frame_strobe && !bus.write_xy;
   assign cnt_last = (cnt_q == CNT_W'(UPDATE_DIV - 1));

   // NOTE: every variable assigned in always_comb gets a value on all paths,
   // otherwise synthesis infers a latch.
   always_comb begin
      x_d = x_q + {{(X_WIDTH - DX_WIDTH){dx_q[DX_WIDTH-1]}}, dx_q};
      y_d = y_q + {{(Y_WIDTH - DY_WIDTH){dy_q[DY_WIDTH-1]}}, dy_q};
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; the step below relies on the old dx_q/dy_q.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         cnt_q    <= '0;
         moving_q <= 1'b0;
         step_q   <= 1'b0;
      end else begin
         step_q <= 1'b0;

         if (bus.write_xy) begin
            x_q   <= bus.write_x;
            y_q   <= bus.write_y;
            cnt_q <= '0;
         end else if (count_en) begin
            if (cnt_last) begin
               cnt_q  <= '0;
               x_q    <= x_d;
               y_q    <= y_d;
               step_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end

         if (bus.write_dxy) begin
            dx_q <= bus.write_dx;
            dy_q <= bus.write_dy;
         end

         // Counter is left untouched on MOVING->ARMED so motion resumes mid-period.
         case (state_q)
            IDLE: begin
               if (bus.write_xy) state_q <= ARMED;
               moving_q <= 1'b0;
            end
            ARMED: begin
               if (bus.enable_update) begin
                  state_q  <= MOVING;
                  moving_q <= 1'b1;
               end else begin
                  moving_q <= 1'b0;
               end
            end
            MOVING: begin
               if (!bus.enable_update) begin
                  state_q  <= ARMED;
                  moving_q <= 1'b0;
               end else begin
                  moving_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= IDLE;
               moving_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sprite_x      = x_q;
   assign bus.sprite_y      = y_q;
   assign bus.sprite_moving = moving_q;
   assign bus.step_pulse    = step_q;

endmodule

// File: tb/tb_game_sprite_motion.sv
// Directed bench for game_sprite_motion: reset, motion, wrap, simultaneous
// load/strobe, pause/resume and mid-operation reset, with hand-computed values.
module tb_game_sprite_motion;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   pulses;

   game_sprite_motion_if #(.X_WIDTH(10), .Y_WIDTH(10), .DX_WIDTH(2), .DY_WIDTH(2)) bus ();

   game_sprite_motion #(
      .X_WIDTH(10), .Y_WIDTH(10), .DX_WIDTH(2), .DY_WIDTH(2), .UPDATE_DIV(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are read at that point too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe();
      bus.frame_strobe = 1'b1;
      tick();
      bus.frame_strobe = 1'b0;
      if (bus.step_pulse) pulses++;
   endtask

   task automatic strobes(input int n);
      for (int i = 0; i < n; i++) strobe();
   endtask

   task automatic write_pos(input logic [9:0] x, input logic [9:0] y);
      bus.write_xy = 1'b1;
      bus.write_x  = x;
      bus.write_y  = y;
      tick();
      bus.write_xy = 1'b0;
   endtask

   task automatic write_vel(input logic [1:0] dx, input logic [1:0] dy);
      bus.write_dxy = 1'b1;
      bus.write_dx  = dx;
      bus.write_dy  = dy;
      tick();
      bus.write_dxy = 1'b0;
   endtask

   task automatic check_pos(input string tag, input int x, input int y);
      check({tag, "_x"}, 32'(bus.sprite_x), 32'(x));
      check({tag, "_y"}, 32'(bus.sprite_y), 32'(y));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      pulses = 0;
      reset = 1'b0;
      bus.frame_strobe  = 1'b0;
      bus.enable_update = 1'b0;
      bus.write_xy      = 1'b0;
      bus.write_x       = '0;
      bus.write_y       = '0;
      bus.write_dxy     = 1'b0;
      bus.write_dx      = '0;
      bus.write_dy      = '0;

      // Reset held with random inputs.
      for (int i = 0; i < 3; i++) begin
         bus.frame_strobe  = 1'($urandom_range(0, 1));
         bus.enable_update = 1'($urandom_range(0, 1));
         bus.write_xy      = 1'($urandom_range(0, 1));
         bus.write_x       = 10'($urandom_range(0, 1023));
         bus.write_y       = 10'($urandom_range(0, 1023));
         bus.write_dxy     = 1'($urandom_range(0, 1));
         bus.write_dx      = 2'($urandom_range(0, 3));
         bus.write_dy      = 2'($urandom_range(0, 3));
         tick();
      end
      check_pos("rst", 0, 0);
      check("rst_moving", 32'(bus.sprite_moving), 0);
      check("rst_pulse", 32'(bus.step_pulse), 0);
      bus.frame_strobe = 1'b0;
      bus.write_xy     = 1'b0;
      bus.write_dxy    = 1'b0;
      reset = 1'b1;

      // Strobes in IDLE are ignored even with enable high.
      bus.enable_update = 1'b1;
      pulses = 0;
      strobes(5);
      check_pos("idle", 0, 0);
      check("idle_moving", 32'(bus.sprite_moving), 0);
      check("idle_pulses", 32'(pulses), 0);

      // Basic motion: (100,50) with (+1,-1).
      bus.enable_update = 1'b0;
      write_vel(2'b01, 2'b11);
      write_pos(10'd100, 10'd50);
      check_pos("load", 100, 50);
      check("armed_moving", 32'(bus.sprite_moving), 0);
      bus.enable_update = 1'b1;
      tick();
      check("moving", 32'(bus.sprite_moving), 1);
      pulses = 0;
      strobes(3);
      check_pos("basic_s3", 100, 50);
      strobe();
      check_pos("basic_s4", 101, 49);
      check("basic_pulse_s4", 32'(bus.step_pulse), 1);
      tick();
      check("pulse_one_cycle", 32'(bus.step_pulse), 0);
      strobes(4);
      check_pos("basic_s8", 102, 48);
      check("basic_pulses", 32'(pulses), 2);
      check("basic_moving", 32'(bus.sprite_moving), 1);

      // Wrap-around in both axes.
      write_pos(10'd1023, 10'd0);
      pulses = 0;
      strobes(4);
      check_pos("wrap", 0, 1023);
      check("wrap_pulses", 32'(pulses), 1);

      // write_xy coincident with the stepping strobe: load wins, counter restarts.
      strobes(3);
      bus.write_xy = 1'b1;
      bus.write_x  = 10'd10;
      bus.write_y  = 10'd10;
      pulses = 0;
      strobe();
      bus.write_xy = 1'b0;
      check_pos("ld_vs_step", 10, 10);
      check("ld_vs_step_pulse", 32'(bus.step_pulse), 0);
      strobes(3);
      check_pos("ld_restart_s3", 10, 10);
      check("ld_restart_pulses", 32'(pulses), 0);
      strobe();
      check_pos("ld_restart_s4", 11, 9);

      // write_dxy coincident with a stepping strobe uses the old velocity.
      strobes(3);
      bus.write_dxy = 1'b1;
      bus.write_dx  = 2'b10;
      bus.write_dy  = 2'b01;
      strobe();
      bus.write_dxy = 1'b0;
      check_pos("vel_old", 12, 8);
      strobes(4);
      check_pos("vel_new", 10, 9);

      // Pause after 2 strobes; counter is retained.
      strobes(2);
      bus.enable_update = 1'b0;
      tick();
      check("pause_moving", 32'(bus.sprite_moving), 0);
      pulses = 0;
      strobes(4);
      check_pos("pause", 10, 9);
      check("pause_pulses", 32'(pulses), 0);
      // Strobe on the ARMED->MOVING edge does not count.
      bus.enable_update = 1'b1;
      strobe();
      check("resume_moving", 32'(bus.sprite_moving), 1);
      strobe();
      check_pos("resume_s1", 10, 9);
      check("resume_pulses", 32'(pulses), 0);
      strobe();
      check_pos("resume_s2", 8, 10);
      check("resume_pulse", 32'(bus.step_pulse), 1);

      // Mid-operation reset with counter at 3.
      strobes(3);
      check_pos("pre_rst", 8, 10);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check_pos("mid_rst", 0, 0);
      check("mid_rst_moving", 32'(bus.sprite_moving), 0);
      check("mid_rst_pulse", 32'(bus.step_pulse), 0);
      pulses = 0;
      strobes(4);
      check_pos("post_rst", 0, 0);
      check("post_rst_pulses", 32'(pulses), 0);
      check("post_rst_moving", 32'(bus.sprite_moving), 0);

      // Velocity was cleared by reset: a zero step still pulses.
      write_pos(10'd5, 10'd5);
      tick();
      check("rearm_moving", 32'(bus.sprite_moving), 1);
      pulses = 0;
      strobes(4);
      check_pos("zero_step", 5, 5);
      check("zero_step_pulses", 32'(pulses), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
